// File: rtl/store_pkg.sv
// Shared types and helpers for the store merge unit: store-type encodings,
// FSM state encoding and word-alignment helpers.
package store_pkg;

  // Store width as presented by the datapath
  typedef enum logic [1:0] {
    ST_B   = 2'b00,
    ST_H   = 2'b01,
    ST_W   = 2'b10,
    ST_ILL = 2'b11
  } st_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWait = 2'b10,
    StWr   = 2'b11
  } state_e;

  // Widest byte address the alignment helper handles
  localparam int unsigned AddrWMax = 64;
  // Latency counter width, enough for RD_LAT-1 up to 3
  localparam int unsigned CntW     = 2;

  // Clear the byte-offset bits to form the word address
  function automatic logic [AddrWMax-1:0] word_align(input logic [AddrWMax-1:0] addr);
    return {addr[AddrWMax-1:2], 2'b00};
  endfunction

  // A request is rejected if its type is illegal or it crosses its natural alignment
  function automatic logic is_bad_req(input st_type_e typ, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    unique case (typ)
      ST_B:    bad = 1'b0;
      ST_H:    bad = off[0];
      ST_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational lane merge: inserts a byte or halfword into a 32-bit word at
// the addressed lane. A full-word store passes the new data straight through.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  offset_i,
  input  st_type_e    type_i,
  output logic [31:0] merged_o
);

  // Start from the old word and overwrite only the addressed lane(s)
  always_comb begin
    merged_o = old_word_i;
    unique case (type_i)
      ST_B: begin
        unique case (offset_i)
          2'd0: merged_o[7:0]   = new_data_i[7:0];
          2'd1: merged_o[15:8]  = new_data_i[7:0];
          2'd2: merged_o[23:16] = new_data_i[7:0];
          2'd3: merged_o[31:24] = new_data_i[7:0];
          default: ;
        endcase
      end
      ST_H: begin
        if (offset_i[1]) merged_o[31:16] = new_data_i[15:0];
        else             merged_o[15:0]  = new_data_i[15:0];
      end
      ST_W:    merged_o = new_data_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: performs sb/sh/sw into a word-wide memory without byte
// enables. Sub-word stores read the word, merge the new lane and write it back;
// full-word stores write directly. Busy stalls the core while a store runs.
// Optional macro STORE_FWD_EN adds a one-entry buffer of the last written word
// so back-to-back sub-word stores to the same word skip the read.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_type,
  output logic              busy,
  output logic              st_done,
  output logic              st_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
`ifdef STORE_FWD_EN
  input  logic              fwd_inv,
`endif
  output logic [31:0]       mem_wr_data
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("store_merge_unit: RD_LAT must be in 1..4");
  end
  if (ADDR_W < 3 || ADDR_W > AddrWMax) begin : g_bad_addr_w
    $error("store_merge_unit: ADDR_W out of supported range");
  end

  localparam logic [CntW-1:0] RdLatM1 = CntW'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  st_type_e          type_q, type_d;
  logic [1:0]        off_q, off_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       old_q, old_d;
  logic              err_q, err_d;

  st_type_e          req_type;
  logic [ADDR_W-1:0] req_word_addr;
  logic              req_bad;
  logic [31:0]       merged;
  logic              fwd_hit;
  logic [31:0]       fwd_word;

  assign req_type      = st_type_e'(st_type);
  assign req_word_addr = ADDR_W'(word_align(AddrWMax'(st_addr)));
  assign req_bad       = is_bad_req(req_type, st_addr[1:0]);

  byte_lane_merge u_merge (
    .old_word_i (old_q),
    .new_data_i (data_q),
    .offset_i   (off_q),
    .type_i     (type_q),
    .merged_o   (merged)
  );

`ifdef STORE_FWD_EN
  logic              fwd_valid_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [31:0]       fwd_data_q;

  // Invalidation beats a same-cycle write since an external writer may have clobbered the word
  assign fwd_hit  = fwd_valid_q && !fwd_inv && (fwd_addr_q == req_word_addr);
  assign fwd_word = fwd_data_q;

  // Last-written-word buffer, refreshed on every write issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else if (fwd_inv) begin
      fwd_valid_q <= 1'b0;
    end else if (state_q == StWr) begin
      fwd_valid_q <= 1'b1;
      fwd_addr_q  <= addr_q;
      fwd_data_q  <= merged;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_word = '0;
`endif

  // Next-state logic: request capture, read sequencing and latency countdown
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    type_d  = type_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    old_d   = old_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (st_req) begin
          addr_d = req_word_addr;
          data_d = st_data;
          type_d = req_type;
          off_d  = st_addr[1:0];
          if (req_bad) begin
            err_d = 1'b1;
          end else if (req_type == ST_W) begin
            state_d = StWr;
          end else if (fwd_hit) begin
            old_d   = fwd_word;
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        cnt_d   = RdLatM1;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          old_d   = mem_rd_data;
          state_d = StWr;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWr: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and request registers; reset aborts any store in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= ST_B;
      off_q   <= '0;
      cnt_q   <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      type_q  <= type_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      old_q   <= old_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode directly from state so strobes drop as soon as reset asserts
  always_comb begin
    busy        = (state_q != StIdle);
    mem_rd_en   = (state_q == StRd);
    mem_wr_en   = (state_q == StWr);
    st_done     = (state_q == StWr);
    st_err      = err_q;
    mem_addr    = (state_q != StIdle) ? addr_q : '0;
    mem_wr_data = (state_q == StWr) ? merged : '0;
  end

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              st_req;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_type;
  logic              busy, st_done, st_err, mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data, mem_wr_data;
  logic              fwd_inv;

  store_merge_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_req      (st_req),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_type     (st_type),
    .busy        (busy),
    .st_done     (st_done),
    .st_err      (st_err),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
`ifdef STORE_FWD_EN
    .fwd_inv     (fwd_inv),
`endif
    .mem_wr_data (mem_wr_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: word array, preload port, RD_LAT-deep read pipeline
  logic [31:0]       mem [0:255];
  logic              pl_en = 1'b0;
  logic [31:0]       pl_addr, pl_data;
  logic [RD_LAT-1:0] rd_v = '0;
  logic [7:0]        rd_a [0:RD_LAT-1];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr[9:2]] <= pl_data;
    if (mem_wr_en === 1'b1) mem[mem_addr[9:2]] <= mem_wr_data;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
    rd_v[0] <= (mem_rd_en === 1'b1);
    rd_a[0] <= mem_addr[9:2];
  end

  always_comb begin
    mem_rd_data = 32'hBAD0BAD0;
    if (rd_v[RD_LAT-1]) mem_rd_data = mem[rd_a[RD_LAT-1]];
  end

  // Scoreboard of expected writes
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;
  exp_t sb_q[$];

  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;

  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) rd_cnt <= rd_cnt + 1;
    if ((mem_wr_en === 1'b1) || (st_done === 1'b1)) begin
      check("done_with_wr", {31'd0, st_done}, {31'd0, mem_wr_en});
    end
    if (mem_wr_en === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      check("write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", mem_addr, e.addr);
        check("wr_data", mem_wr_data, e.data);
        check("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    fwd_inv = 1'b1;  // preload acts as an external writer
    tick();
    pl_en   = 1'b0;
    fwd_inv = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] t, input logic [31:0] exp_word,
                          input int unsigned lat, input int unsigned exp_rd);
    int unsigned rd0;
    int unsigned bcnt;
    exp_t e;
    rd0  = rd_cnt;
    bcnt = 0;
    e.addr = {a[31:2], 2'b00};
    e.data = exp_word;
    e.cyc  = cyc + lat;
    sb_q.push_back(e);
    st_req  = 1'b1;
    st_addr = a;
    st_data = d;
    st_type = t;
    tick();
    st_req  = 1'b0;
    st_data = $urandom;
    st_addr = $urandom;
    while (busy === 1'b1 && bcnt < 20) begin
      bcnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, bcnt, lat);
    check({tag, "_reads"}, rd_cnt - rd0, exp_rd);
    check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_err(input string tag, input logic [31:0] a, input logic [1:0] t);
    int unsigned rd0;
    int unsigned wr0;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    st_req  = 1'b1;
    st_addr = a;
    st_data = 32'h12345678;
    st_type = t;
    tick();
    st_req = 1'b0;
    check({tag, "_err_pulse"}, {31'd0, st_err}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_err_clear"}, {31'd0, st_err}, 32'd0);
    tick();
    check({tag, "_no_rd"}, rd_cnt - rd0, 32'd0);
    check({tag, "_no_wr"}, wr_cnt - wr0, 32'd0);
  endtask

  function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] off, input logic is_half);
    logic [31:0] mask;
    mask = is_half ? (32'h0000FFFF << (8 * off)) : (32'h000000FF << (8 * off));
    return (old & ~mask) | ((d << (8 * off)) & mask);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned wr0;
    logic [31:0] old, d, a;

    rst_n   = 1'b0;
    st_req  = 1'b0;
    st_addr = '0;
    st_data = '0;
    st_type = 2'b00;
    fwd_inv = 1'b0;
    tick();
    tick();
    check("reset_ctrl", {27'd0, busy, st_done, st_err, mem_rd_en, mem_wr_en}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_wr_data, 32'd0);
    rst_n = 1'b1;
    tick();

    do_store("sw_basic", 32'h100, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF, 1, 0);

    preload(32'h100, 32'h11223344);
    do_store("sb_lane2", 32'h102, 32'h000000AA, 2'b00, 32'h11AA3344, RD_LAT + 2, 1);

    preload(32'h104, 32'hCAFEF00D);
    do_store("sh_hi", 32'h106, 32'h0000BEEF, 2'b01, 32'hBEEFF00D, RD_LAT + 2, 1);

    do_err("sh_mis", 32'h101, 2'b01);
    do_err("sw_mis", 32'h102, 2'b10);
    do_err("illegal", 32'h100, 2'b11);

    // Every lane of sb and both halves of sh against the mask model
    for (int i = 0; i < 6; i++) begin
      a   = 32'h300 + 32'(i * 4) + ((i < 4) ? 32'(i) : 32'((i - 4) * 2));
      old = $urandom;
      d   = $urandom;
      preload(a, old);
      do_store("lane_sweep", a, d, (i < 4) ? 2'b00 : 2'b01,
               merge_model(old, d, a[1:0], i >= 4), RD_LAT + 2, 1);
    end

    // A request raised while busy must be ignored
    preload(32'h140, 32'hA5A5A5A5);
    begin
      exp_t e;
      int unsigned bcnt;
      e.addr = 32'h140;
      e.data = 32'hA5A53CA5;
      e.cyc  = cyc + RD_LAT + 2;
      sb_q.push_back(e);
      wr0     = wr_cnt;
      st_req  = 1'b1;
      st_addr = 32'h141;
      st_data = 32'h3C;
      st_type = 2'b00;
      tick();
      st_addr = 32'h1F0;
      st_data = 32'h77777777;
      st_type = 2'b10;
      tick();
      st_req = 1'b0;
      bcnt = 0;
      while (busy === 1'b1 && bcnt < 20) begin
        bcnt++;
        tick();
      end
      tick();
      check("busy_req_ignored", wr_cnt - wr0, 32'd1);
      check("busy_req_drained", 32'(sb_q.size()), 32'd0);
    end

    // Reset during WAIT must abort with no write
    preload(32'h180, 32'h01020304);
    wr0     = wr_cnt;
    st_req  = 1'b1;
    st_addr = 32'h181;
    st_data = 32'hEE;
    st_type = 2'b00;
    tick();
    st_req = 1'b0;
    tick();
    check("mid_op_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", {28'd0, busy, st_done, mem_rd_en, mem_wr_en}, 32'd0);
    check("rst_async_addr", mem_addr, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("rst_no_write", wr_cnt - wr0, 32'd0);
    do_store("sw_after_rst", 32'h184, 32'hFEEDF00D, 2'b10, 32'hFEEDF00D, 1, 0);

`ifdef STORE_FWD_EN
    preload(32'h200, 32'h99887766);
    do_store("fwd_first", 32'h200, 32'h11, 2'b00, 32'h99887711, RD_LAT + 2, 1);
    do_store("fwd_hit", 32'h201, 32'h55, 2'b00, 32'h99885511, 1, 0);
    fwd_inv = 1'b1;
    tick();
    fwd_inv = 1'b0;
    do_store("fwd_inv_read", 32'h202, 32'h33, 2'b00, 32'h99335511, RD_LAT + 2, 1);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
